// File: rtl/vco_pair_meas_ctrl.sv
// Measurement sequencer for two ring VCOs: resets the selected VCO, lets it settle,
// then counts its synchronized divided output edges over a fixed gate window.
module vco_pair_meas_ctrl #(
    parameter int CNT_W         = 16,
    parameter int RST_CYCLES    = 16,
    parameter int SETTLE_CYCLES = 64,
    parameter int GATE_CYCLES   = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             auto_alt,
    input  logic             chan_sel,
    input  logic             continuous,
    input  logic [1:0]       vco_div_in,
    output logic [1:0]       vco_rst,
    output logic             busy,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [CNT_W-1:0] result_count,
    output logic             result_chan,
    output logic             result_sat
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_SETTLE,
        S_GATE,
        S_REPORT
    } state_t;

    localparam logic [31:0]      RST_LAST    = 32'(RST_CYCLES - 1);
    localparam logic [31:0]      SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0]      GATE_LAST   = 32'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [31:0]      timer_q, timer_d;
    logic             ch_q, ch_d;
    logic             alt_mode_q, alt_mode_d;
    logic             next_alt_q, next_alt_d;
    logic             start_q, start_d;
    logic             pend_ch_q, pend_ch_d;
    logic             pend_alt_q, pend_alt_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             sat_q, sat_d;
    logic [1:0]       sync1_q, sync1_d;
    logic [1:0]       sync2_q, sync2_d;
    logic [1:0]       prev_q, prev_d;
    logic [1:0]       vco_rst_q, vco_rst_d;
    logic             busy_q, busy_d;
    logic             result_valid_q, result_valid_d;
    logic [CNT_W-1:0] result_count_q, result_count_d;
    logic             result_chan_q, result_chan_d;
    logic             result_sat_q, result_sat_d;
    logic [1:0]       rise;
    logic             nalt;

    assign rise = sync2_q & ~prev_q;

    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        ch_d           = ch_q;
        alt_mode_d     = alt_mode_q;
        next_alt_d     = next_alt_q;
        count_d        = count_q;
        sat_d          = sat_q;
        result_valid_d = result_valid_q;
        result_count_d = result_count_q;
        result_chan_d  = result_chan_q;
        result_sat_d   = result_sat_q;
        nalt           = next_alt_q;
        sync1_d        = vco_div_in;
        sync2_d        = sync1_q;
        prev_d         = sync2_q;

        // start is registered once so the mode inputs are captured with the pulse
        start_d    = start && (state_q == S_IDLE);
        pend_ch_d  = pend_ch_q;
        pend_alt_d = pend_alt_q;
        if (start && (state_q == S_IDLE)) begin
            pend_ch_d  = auto_alt ? next_alt_q : chan_sel;
            pend_alt_d = auto_alt;
        end

        case (state_q)
            S_IDLE: begin
                if (start_q) begin
                    ch_d       = pend_ch_q;
                    alt_mode_d = pend_alt_q;
                    timer_d    = '0;
                    state_d    = S_RESET;
                end
            end
            S_RESET: begin
                if (timer_q == RST_LAST) begin
                    timer_d = '0;
                    state_d = S_SETTLE;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            S_SETTLE: begin
                count_d = '0;
                sat_d   = 1'b0;
                if (timer_q == SETTLE_LAST) begin
                    timer_d = '0;
                    state_d = S_GATE;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            S_GATE: begin
                if (rise[ch_q] && (count_q != CNT_MAX)) begin
                    count_d = count_q + CNT_ONE;
                end
                sat_d = sat_q | (count_d == CNT_MAX);
                if (timer_q == GATE_LAST) begin
                    timer_d        = '0;
                    result_count_d = count_d;
                    result_chan_d  = ch_q;
                    result_sat_d   = sat_d;
                    result_valid_d = 1'b1;
                    state_d        = S_REPORT;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            S_REPORT: begin
                if (result_valid_q && result_ready) begin
                    result_valid_d = 1'b0;
                    nalt           = alt_mode_q ? ~next_alt_q : next_alt_q;
                    next_alt_d     = nalt;
                    if (continuous) begin
                        ch_d       = auto_alt ? nalt : chan_sel;
                        alt_mode_d = auto_alt;
                        timer_d    = '0;
                        state_d    = S_RESET;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs derive from the next state so they line up with state_q
        vco_rst_d = 2'b11;
        if ((state_d == S_SETTLE) || (state_d == S_GATE) || (state_d == S_REPORT)) begin
            vco_rst_d[ch_d] = 1'b0;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            timer_q        <= '0;
            ch_q           <= 1'b0;
            alt_mode_q     <= 1'b0;
            next_alt_q     <= 1'b0;
            start_q        <= 1'b0;
            pend_ch_q      <= 1'b0;
            pend_alt_q     <= 1'b0;
            count_q        <= '0;
            sat_q          <= 1'b0;
            sync1_q        <= '0;
            sync2_q        <= '0;
            prev_q         <= '0;
            vco_rst_q      <= 2'b11;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            result_count_q <= '0;
            result_chan_q  <= 1'b0;
            result_sat_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            ch_q           <= ch_d;
            alt_mode_q     <= alt_mode_d;
            next_alt_q     <= next_alt_d;
            start_q        <= start_d;
            pend_ch_q      <= pend_ch_d;
            pend_alt_q     <= pend_alt_d;
            count_q        <= count_d;
            sat_q          <= sat_d;
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            prev_q         <= prev_d;
            vco_rst_q      <= vco_rst_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
            result_count_q <= result_count_d;
            result_chan_q  <= result_chan_d;
            result_sat_q   <= result_sat_d;
        end
    end

    assign vco_rst      = vco_rst_q;
    assign busy         = busy_q;
    assign result_valid = result_valid_q;
    assign result_count = result_count_q;
    assign result_chan  = result_chan_q;
    assign result_sat   = result_sat_q;

endmodule

// File: tb/tb_vco_pair_meas_ctrl.sv
// Scoreboard bench for vco_pair_meas_ctrl: default-width instance plus an 8-bit
// counter instance used for the saturation case.
module tb_vco_pair_meas_ctrl;

    localparam int R    = 16;
    localparam int S    = 64;
    localparam int G    = 1024;
    localparam int LAT  = R + S + G + 2;
    localparam int INTV = R + S + G + 1;

    typedef struct {
        logic chan;
        int   cnt;
        logic sat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, auto_alt, chan_sel, continuous, ready;
    logic        div0 = 1'b0, div1 = 1'b0, div2 = 1'b0;
    logic [1:0]  vco_rst;
    logic        busy, result_valid, result_chan, result_sat;
    logic [15:0] result_count;

    logic        start8, ready8;
    logic [1:0]  vco_rst8;
    logic        busy8, result_valid8, result_chan8, result_sat8;
    logic [7:0]  result_count8;

    int per0 = 0, per1 = 0, per2 = 0;
    int tests_run = 0;
    int failed = 0;
    exp_t sbq[$];
    exp_t sbq8[$];

    always #5 clk = ~clk;

    vco_pair_meas_ctrl #(.CNT_W(16), .RST_CYCLES(R), .SETTLE_CYCLES(S), .GATE_CYCLES(G)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .auto_alt(auto_alt), .chan_sel(chan_sel),
        .continuous(continuous), .vco_div_in({div1, div0}), .vco_rst(vco_rst), .busy(busy),
        .result_valid(result_valid), .result_ready(ready), .result_count(result_count),
        .result_chan(result_chan), .result_sat(result_sat)
    );

    vco_pair_meas_ctrl #(.CNT_W(8), .RST_CYCLES(R), .SETTLE_CYCLES(S), .GATE_CYCLES(G)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .auto_alt(1'b0), .chan_sel(1'b0),
        .continuous(1'b0), .vco_div_in({1'b0, div2}), .vco_rst(vco_rst8), .busy(busy8),
        .result_valid(result_valid8), .result_ready(ready8), .result_count(result_count8),
        .result_chan(result_chan8), .result_sat(result_sat8)
    );

    // VCO stand-ins: edges offset by 2 time units so they never coincide with clk edges
    initial begin
        #2;
        forever begin
            if (per0 == 0) begin div0 = 1'b0; #10; end
            else begin #(per0 * 5); div0 = ~div0; end
        end
    end
    initial begin
        #2;
        forever begin
            if (per1 == 0) begin div1 = 1'b0; #10; end
            else begin #(per1 * 5); div1 = ~div1; end
        end
    end
    initial begin
        #2;
        forever begin
            if (per2 == 0) begin div2 = 1'b0; #10; end
            else begin #(per2 * 5); div2 = ~div2; end
        end
    end

    function automatic exp_t model(input logic ch, input int per, input int w);
        exp_t e;
        int mx;
        mx    = (1 << w) - 1;
        e.chan = ch;
        e.cnt  = G / per;
        e.sat  = 1'b0;
        if (e.cnt >= mx) begin
            e.cnt = mx;
            e.sat = 1'b1;
        end
        return e;
    endfunction

    task automatic test_reset;
        start = 0; auto_alt = 0; chan_sel = 0; continuous = 0; ready = 0;
        start8 = 0; ready8 = 0;
        rst_n = 0;
        repeat (3) @(negedge clk);
        tests_run++; if (vco_rst !== 2'b11) begin failed++; $display("FAIL reset_vco_rst got=%b exp=11", vco_rst); end
        tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests_run++; if (result_valid !== 1'b0) begin failed++; $display("FAIL reset_valid got=%b exp=0", result_valid); end
        tests_run++; if (result_count !== 16'd0) begin failed++; $display("FAIL reset_count got=%0d exp=0", result_count); end
        tests_run++; if ({result_chan, result_sat} !== 2'b00) begin failed++; $display("FAIL reset_chan_sat got=%b exp=00", {result_chan, result_sat}); end
        tests_run++; if (vco_rst8 !== 2'b11) begin failed++; $display("FAIL reset_vco_rst8 got=%b exp=11", vco_rst8); end
        rst_n = 1;
        @(negedge clk);
        tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single;
        exp_t e;
        int k;
        bit seen;
        per0 = 0; per1 = 8; auto_alt = 0; chan_sel = 1; continuous = 0; ready = 0;
        repeat (5) @(negedge clk);
        sbq.push_back(model(1'b1, 8, 16));
        start = 1; k = 0; seen = 0;
        while (k < LAT + 200 && !seen) begin
            @(negedge clk); k++; start = 0;
            if (k == 4) begin
                tests_run++; if ({busy, vco_rst} !== 3'b111) begin failed++; $display("FAIL single_in_reset busy,vco_rst got=%b exp=111", {busy, vco_rst}); end
            end
            if (k == R + 10) begin
                tests_run++; if (vco_rst !== 2'b01) begin failed++; $display("FAIL single_settle_vco_rst got=%b exp=01", vco_rst); end
            end
            if (k == R + S + 100) begin
                tests_run++; if (vco_rst !== 2'b01) begin failed++; $display("FAIL single_gate_vco_rst got=%b exp=01", vco_rst); end
            end
            if (result_valid) seen = 1;
        end
        tests_run++;
        if (!seen) begin
            failed++; $display("FAIL single_timeout got=no_valid exp=valid_at_%0d", LAT);
            sbq.delete();
        end else begin
            e = sbq.pop_front();
            tests_run++; if (k !== LAT) begin failed++; $display("FAIL single_latency got=%0d exp=%0d", k, LAT); end
            tests_run++; if (result_chan !== e.chan) begin failed++; $display("FAIL single_chan got=%b exp=%b", result_chan, e.chan); end
            tests_run++; if (int'(result_count) < e.cnt - 1 || int'(result_count) > e.cnt + 1) begin failed++; $display("FAIL single_count got=%0d exp=%0d+/-1", result_count, e.cnt); end
            tests_run++; if (result_sat !== e.sat) begin failed++; $display("FAIL single_sat got=%b exp=%b", result_sat, e.sat); end
            tests_run++; if (vco_rst !== 2'b01) begin failed++; $display("FAIL single_report_vco_rst got=%b exp=01", vco_rst); end
        end
        ready = 1;
        @(negedge clk);
        ready = 0;
        tests_run++; if ({result_valid, busy, vco_rst} !== 4'b0011) begin failed++; $display("FAIL single_after_hs valid,busy,vco_rst got=%b exp=0011", {result_valid, busy, vco_rst}); end
    endtask

    task automatic test_alternate;
        exp_t e;
        int cyc, last, budget;
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        per0 = 4; per1 = 16; auto_alt = 1; continuous = 1; ready = 1; chan_sel = 0;
        repeat (3) @(negedge clk);
        for (int n = 0; n < 4; n++) sbq.push_back(model(n[0], n[0] ? 16 : 4, 16));
        start = 1;
        @(negedge clk);
        start = 0; cyc = 1; last = 0;
        for (int n = 0; n < 4; n++) begin
            budget = 0;
            while (!result_valid && budget < LAT + 200) begin
                @(negedge clk); cyc++; budget++;
            end
            tests_run++;
            if (!result_valid) begin
                failed++; $display("FAIL alt_timeout run=%0d got=no_valid exp=valid", n);
                sbq.delete();
                break;
            end
            e = sbq.pop_front();
            tests_run++; if (result_chan !== e.chan) begin failed++; $display("FAIL alt_chan run=%0d got=%b exp=%b", n, result_chan, e.chan); end
            tests_run++; if (int'(result_count) < e.cnt - 1 || int'(result_count) > e.cnt + 1) begin failed++; $display("FAIL alt_count run=%0d got=%0d exp=%0d+/-1", n, result_count, e.cnt); end
            tests_run++; if (result_sat !== 1'b0) begin failed++; $display("FAIL alt_sat run=%0d got=%b exp=0", n, result_sat); end
            if (n > 0) begin
                tests_run++; if (cyc - last !== INTV) begin failed++; $display("FAIL alt_interval run=%0d got=%0d exp=%0d", n, cyc - last, INTV); end
            end
            last = cyc;
            @(negedge clk); cyc++;
            tests_run++; if (result_valid !== 1'b0) begin failed++; $display("FAIL alt_valid_pulse run=%0d got=%b exp=0", n, result_valid); end
            if (n == 2) continuous = 0;
        end
        tests_run++; if ({busy, vco_rst} !== 3'b011) begin failed++; $display("FAIL alt_end busy,vco_rst got=%b exp=011", {busy, vco_rst}); end
        auto_alt = 0; per0 = 0; per1 = 0;
    endtask

    task automatic test_saturate;
        exp_t e;
        int budget;
        per2 = 2; ready8 = 0;
        repeat (3) @(negedge clk);
        sbq8.push_back(model(1'b0, 2, 8));
        start8 = 1;
        @(negedge clk);
        start8 = 0; budget = 0;
        while (!result_valid8 && budget < LAT + 200) begin
            @(negedge clk); budget++;
        end
        tests_run++;
        if (!result_valid8) begin
            failed++; $display("FAIL sat_timeout got=no_valid exp=valid");
            sbq8.delete();
        end else begin
            e = sbq8.pop_front();
            tests_run++; if (int'(result_count8) !== e.cnt) begin failed++; $display("FAIL sat_count got=%0d exp=%0d", result_count8, e.cnt); end
            tests_run++; if (result_sat8 !== e.sat) begin failed++; $display("FAIL sat_flag got=%b exp=%b", result_sat8, e.sat); end
            tests_run++; if (result_chan8 !== e.chan) begin failed++; $display("FAIL sat_chan got=%b exp=%b", result_chan8, e.chan); end
        end
        ready8 = 1;
        @(negedge clk);
        ready8 = 0; per2 = 0;
        tests_run++; if ({result_valid8, busy8} !== 2'b00) begin failed++; $display("FAIL sat_after_hs valid,busy got=%b exp=00", {result_valid8, busy8}); end
    endtask

    task automatic test_backpressure;
        exp_t e;
        int budget;
        logic [15:0] hold;
        per0 = 8; per1 = 0; auto_alt = 0; chan_sel = 0; continuous = 0; ready = 0;
        repeat (3) @(negedge clk);
        sbq.push_back(model(1'b0, 8, 16));
        start = 1;
        @(negedge clk);
        start = 0; budget = 0;
        while (!result_valid && budget < LAT + 200) begin
            @(negedge clk); budget++;
        end
        tests_run++;
        if (!result_valid) begin
            failed++; $display("FAIL bp_timeout got=no_valid exp=valid");
            sbq.delete();
        end else begin
            e = sbq.pop_front();
            tests_run++; if (int'(result_count) < e.cnt - 1 || int'(result_count) > e.cnt + 1) begin failed++; $display("FAIL bp_count got=%0d exp=%0d+/-1", result_count, e.cnt); end
            hold = result_count;
            for (int i = 0; i < 50; i++) begin
                start = (i % 10 == 3);
                @(negedge clk);
                tests_run++; if (result_valid !== 1'b1) begin failed++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", i, result_valid); end
                tests_run++; if (result_count !== hold) begin failed++; $display("FAIL bp_count_stable cyc=%0d got=%0d exp=%0d", i, result_count, hold); end
                tests_run++; if (result_chan !== e.chan) begin failed++; $display("FAIL bp_chan cyc=%0d got=%b exp=%b", i, result_chan, e.chan); end
            end
        end
        start = 0; ready = 1;
        @(negedge clk);
        ready = 0;
        tests_run++; if ({result_valid, busy} !== 2'b00) begin failed++; $display("FAIL bp_after_hs valid,busy got=%b exp=00", {result_valid, busy}); end
        repeat (4) @(negedge clk);
        tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL bp_start_ignored busy got=%b exp=0", busy); end
        per0 = 0;
    endtask

    task automatic test_abort;
        bit ever;
        per1 = 8; chan_sel = 1; auto_alt = 0; continuous = 0; ready = 0;
        repeat (3) @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (R + S + 200) @(negedge clk);
        tests_run++; if ({busy, vco_rst} !== 3'b101) begin failed++; $display("FAIL abort_in_gate busy,vco_rst got=%b exp=101", {busy, vco_rst}); end
        rst_n = 0;
        @(negedge clk);
        tests_run++; if ({busy, vco_rst, result_valid} !== 4'b0110) begin failed++; $display("FAIL abort_state busy,vco_rst,valid got=%b exp=0110", {busy, vco_rst, result_valid}); end
        tests_run++; if (result_count !== 16'd0) begin failed++; $display("FAIL abort_count got=%0d exp=0", result_count); end
        rst_n = 1; ever = 0;
        repeat (LAT + 100) begin
            @(negedge clk);
            if (result_valid) ever = 1;
        end
        tests_run++; if (ever !== 1'b0) begin failed++; $display("FAIL abort_no_result got=valid_seen exp=none"); end
        per1 = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_saturate();
        test_backpressure();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
